// File: rtl/conveyor_indexer_if.sv
// Signal bundle between the filler/line side and the conveyor indexer.
// The master side drives sensors and filler status; the slave side is the indexer.
interface conveyor_indexer_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             valve_close;
  logic [7:0]       current_count;
  logic [7:0]       target_limit;
  logic             bottle_at_station;
  logic             fault_clear;
  logic             conveyor_run;
  logic             capper_on;
  logic             new_bottle_signal;
  logic             reject_flag;
  logic             fault;
  logic [CNT_W-1:0] bottles_done;
  logic [CNT_W-1:0] rejects;

  modport master (
    output enable, valve_close, current_count, target_limit,
           bottle_at_station, fault_clear,
    input  conveyor_run, capper_on, new_bottle_signal, reject_flag,
           fault, bottles_done, rejects
  );

  modport slave (
    input  enable, valve_close, current_count, target_limit,
           bottle_at_station, fault_clear,
    output conveyor_run, capper_on, new_bottle_signal, reject_flag,
           fault, bottles_done, rejects
  );
endinterface

// File: rtl/conveyor_indexer.sv
// Conveyor indexer: settles and caps a full bottle (or skips capping when
// overfilled), indexes the conveyor to the next bottle, pulses the filler
// and keeps good/reject tallies. Jams during the index move latch a fault.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for enable & valve_close & bottle under the chute
// S_SETTLE   | letting the fill settle; overfill verdict taken on last cycle
// S_CAP      | capping head down
// S_MOVE     | conveyor running: bottle leaves (OUT), next one arrives (IN)
// S_RELEASE  | one-cycle pulse to the filler, tally updated
// S_WAIT_CLR | waiting for the filler to drop valve_close
// S_FAULT    | jam latched until operator acknowledge
module conveyor_indexer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CAP_CYCLES    = 8,
  parameter int MOVE_TIMEOUT  = 64,
  parameter int CNT_W         = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  conveyor_indexer_if.slave  bus_io
);

  // One shared down-counter serves all timed states.
  localparam int TMAX_SC = (SETTLE_CYCLES > CAP_CYCLES) ? SETTLE_CYCLES : CAP_CYCLES;
  localparam int TMAX    = (TMAX_SC > MOVE_TIMEOUT) ? TMAX_SC : MOVE_TIMEOUT;
  localparam int TW      = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] CAP_LD    = TW'(CAP_CYCLES - 1);
  localparam logic [TW-1:0] MOVE_LD   = TW'(MOVE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAP,
    S_MOVE,
    S_RELEASE,
    S_WAIT_CLR,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             phase_in_q, phase_in_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] rej_q, rej_d;
  logic             reject_flag_q, reject_flag_d;
  logic             run_q, cap_q, pulse_q, fault_q;

  // Next-state, timer and tally logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    phase_in_d    = phase_in_q;
    ovf_d         = ovf_q;
    done_d        = done_q;
    rej_d         = rej_q;
    reject_flag_d = reject_flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus_io.enable && bus_io.valve_close && bus_io.bottle_at_station) begin
          state_d = S_SETTLE;
          timer_d = SETTLE_LD;
        end
      end

      S_SETTLE: begin
        if (timer_q == '0) begin
          ovf_d = (bus_io.current_count > bus_io.target_limit);
          if (ovf_d) begin
            state_d    = S_MOVE;
            timer_d    = MOVE_LD;
            phase_in_d = 1'b0;
          end else begin
            state_d = S_CAP;
            timer_d = CAP_LD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_CAP: begin
        if (timer_q == '0) begin
          state_d    = S_MOVE;
          timer_d    = MOVE_LD;
          phase_in_d = 1'b0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_MOVE: begin
        // Arrival only counts once the previous bottle has left the sensor.
        if (phase_in_q && bus_io.bottle_at_station) begin
          state_d       = S_RELEASE;
          reject_flag_d = ovf_q;
          if (ovf_q) begin
            rej_d = (rej_q == '1) ? rej_q : rej_q + 1'b1;
          end else begin
            done_d = (done_q == '1) ? done_q : done_q + 1'b1;
          end
        end else if (timer_q == '0) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q - 1'b1;
          if (!bus_io.bottle_at_station) begin
            phase_in_d = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        state_d = S_WAIT_CLR;
      end

      S_WAIT_CLR: begin
        if (!bus_io.valve_close) begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        if (bus_io.fault_clear) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, timers, tallies and Moore outputs registered together so outputs
  // always reflect the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      phase_in_q    <= 1'b0;
      ovf_q         <= 1'b0;
      done_q        <= '0;
      rej_q         <= '0;
      reject_flag_q <= 1'b0;
      run_q         <= 1'b0;
      cap_q         <= 1'b0;
      pulse_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      phase_in_q    <= phase_in_d;
      ovf_q         <= ovf_d;
      done_q        <= done_d;
      rej_q         <= rej_d;
      reject_flag_q <= reject_flag_d;
      run_q         <= (state_d == S_MOVE);
      cap_q         <= (state_d == S_CAP);
      pulse_q       <= (state_d == S_RELEASE);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign bus_io.conveyor_run      = run_q;
  assign bus_io.capper_on         = cap_q;
  assign bus_io.new_bottle_signal = pulse_q;
  assign bus_io.reject_flag       = reject_flag_q;
  assign bus_io.fault             = fault_q;
  assign bus_io.bottles_done      = done_q;
  assign bus_io.rejects           = rej_q;

endmodule

// File: tb/tb_conveyor_indexer.sv
// Bench for conveyor_indexer: a transaction-level model of one bottle at a
// time (capper time, move time, latency, tallies) plus a narrow-counter
// instance sharing the same stimulus so counter saturation is reachable.
module tb_conveyor_indexer;
  localparam int SETTLE    = 4;
  localparam int CAP       = 8;
  localparam int TMO       = 64;
  localparam int SMALL_MAX = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_done = 0;
  int   exp_rej  = 0;
  logic exp_flag = 1'b0;

  always #5 clk = ~clk;

  conveyor_indexer_if #(.CNT_W(16)) bus_m ();
  conveyor_indexer_if #(.CNT_W(3))  bus_s ();

  assign bus_s.enable            = bus_m.enable;
  assign bus_s.valve_close       = bus_m.valve_close;
  assign bus_s.current_count     = bus_m.current_count;
  assign bus_s.target_limit      = bus_m.target_limit;
  assign bus_s.bottle_at_station = bus_m.bottle_at_station;
  assign bus_s.fault_clear       = bus_m.fault_clear;

  conveyor_indexer #(
    .SETTLE_CYCLES(SETTLE), .CAP_CYCLES(CAP), .MOVE_TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus_io(bus_m)
  );

  conveyor_indexer #(
    .SETTLE_CYCLES(SETTLE), .CAP_CYCLES(CAP), .MOVE_TIMEOUT(TMO), .CNT_W(3)
  ) dut_s (
    .clk_i(clk), .reset_i(reset), .bus_io(bus_s)
  );

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_bottles_done"}, bus_m.bottles_done, exp_done);
    chk({tag, "_rejects"}, bus_m.rejects, exp_rej);
    chk({tag, "_small_done"}, bus_s.bottles_done, (exp_done > SMALL_MAX) ? SMALL_MAX : exp_done);
    chk({tag, "_small_rej"}, bus_s.rejects, (exp_rej > SMALL_MAX) ? SMALL_MAX : exp_rej);
  endtask

  // Any visible activity over a window is an error.
  task automatic quiet(input int cycles, input string tag);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_m.capper_on || bus_m.conveyor_run || bus_m.new_bottle_signal || bus_m.fault)
        act++;
    end
    chk(tag, act, 0);
  endtask

  // One bottle. mode 0: sensor drops after d run cycles, back after g more.
  // mode 1: sensor never drops. mode 2: drops after d, never returns.
  task automatic run_bottle(input int mode, input int d, input int g,
                            input logic [7:0] c, input logic [7:0] t, input int stale_k);
    int cap_n = 0, run_n = 0, pulse_n = 0, end_n = 0;
    int exp_cap, m;
    bit saw_fault = 0, stop = 0, ovf;
    ovf     = (c > t);
    exp_cap = ovf ? 0 : CAP;
    bus_m.current_count     = c;
    bus_m.target_limit      = t;
    bus_m.bottle_at_station = 1'b1;
    bus_m.enable            = 1'b1;
    bus_m.fault_clear       = 1'b0;
    bus_m.valve_close       = 1'b1;
    for (int n = 1; n <= 300 && !stop; n++) begin
      @(negedge clk);
      if (bus_m.capper_on) cap_n++;
      if (bus_m.conveyor_run) run_n++;
      if (bus_m.new_bottle_signal) begin pulse_n++; stop = 1; end
      if (bus_m.fault) begin saw_fault = 1; stop = 1; end
      if (stop) begin
        end_n = n;
      end else begin
        // verdict is already taken once capping or moving is visible
        if (bus_m.capper_on || bus_m.conveyor_run) bus_m.current_count = 8'($urandom);
        bus_m.enable      = 1'($urandom_range(0, 1));
        bus_m.fault_clear = ($urandom_range(0, 3) == 0);
        if (bus_m.conveyor_run) begin
          case (mode)
            0:       bus_m.bottle_at_station = !((run_n > d) && (run_n <= d + g));
            1:       bus_m.bottle_at_station = 1'b1;
            default: bus_m.bottle_at_station = !(run_n > d);
          endcase
        end
      end
    end
    bus_m.enable      = 1'b1;
    bus_m.fault_clear = 1'b0;

    chk("capper_cycles", cap_n, exp_cap);
    if (mode == 0) begin
      m = d + g + 1;
      chk("run_cycles", run_n, m);
      chk("pulse_count", pulse_n, 1);
      chk("pulse_latency", end_n, SETTLE + exp_cap + m + 1);
      if (ovf) exp_rej++; else exp_done++;
      exp_flag = ovf;
      chk("reject_flag", bus_m.reject_flag, exp_flag);
      check_counts("release");
      quiet(stale_k, "stale_valve_hold");
      bus_m.valve_close = 1'b0;
      quiet(2, "valve_drop");
    end else begin
      chk("jam_fault", saw_fault, 1);
      chk("jam_pulse", pulse_n, 0);
      chk("jam_run_cycles", run_n, TMO);
      chk("jam_fault_time", end_n, SETTLE + exp_cap + TMO + 1);
      chk("jam_outputs_off", {bus_m.conveyor_run, bus_m.capper_on, bus_m.new_bottle_signal}, 0);
      chk("jam_flag_kept", bus_m.reject_flag, exp_flag);
      check_counts("jam");
      repeat (3) @(negedge clk);
      chk("fault_held", bus_m.fault, 1);
      bus_m.fault_clear = 1'b1;
      bus_m.valve_close = 1'b0;
      @(negedge clk);
      chk("fault_cleared", bus_m.fault, 0);
      bus_m.fault_clear       = 1'b0;
      bus_m.valve_close       = 1'b1;
      bus_m.bottle_at_station = 1'b0;
      quiet(SETTLE + CAP + 2, "no_bottle_idle");
      bus_m.valve_close       = 1'b0;
      bus_m.bottle_at_station = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, ci, mode, w;
    reset = 1'b1;
    bus_m.enable            = 1'b0;
    bus_m.valve_close       = 1'b0;
    bus_m.current_count     = 8'd0;
    bus_m.target_limit      = 8'd0;
    bus_m.bottle_at_station = 1'b1;
    bus_m.fault_clear       = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_outputs", {bus_m.conveyor_run, bus_m.capper_on, bus_m.new_bottle_signal,
                                bus_m.reject_flag, bus_m.fault}, 0);
    check_counts("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // normal: sensor drops on the 3rd move cycle, back 6 cycles later
    run_bottle(0, 2, 6, 8'd5, 8'd5, 10);
    // overfill
    run_bottle(0, 2, 6, 8'd6, 8'd5, 10);

    // enable low blocks the start
    bus_m.enable      = 1'b0;
    bus_m.valve_close = 1'b1;
    quiet(SETTLE + CAP + 2, "enable_gate");
    bus_m.valve_close = 1'b0;
    bus_m.enable      = 1'b1;
    @(negedge clk);

    // jams: sensor never returns / never drops
    run_bottle(2, 2, 0, 8'd5, 8'd5, 6);
    run_bottle(1, 0, 0, 8'd3, 8'd9, 6);

    // reset in the middle of capping
    bus_m.current_count     = 8'd5;
    bus_m.target_limit      = 8'd5;
    bus_m.bottle_at_station = 1'b1;
    bus_m.valve_close       = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!bus_m.capper_on && w < 30);
    chk("cap_reached", bus_m.capper_on, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_done = 0; exp_rej = 0; exp_flag = 1'b0;
    chk("reset_mid_cap_outputs", {bus_m.conveyor_run, bus_m.capper_on, bus_m.new_bottle_signal,
                                  bus_m.reject_flag, bus_m.fault}, 0);
    check_counts("reset_mid_cap");
    reset = 1'b0;
    bus_m.valve_close = 1'b0;
    quiet(SETTLE + CAP + 10, "reset_abort_quiet");
    check_counts("reset_abort");

    // randomized bottles
    for (int b = 0; b < 40; b++) begin
      ti = int'($urandom_range(0, 254));
      case ($urandom_range(0, 3))
        0:       ci = ti;
        1:       ci = ti + 1;
        2:       ci = int'($urandom_range(0, ti));
        default: ci = int'($urandom_range(ti + 1, 255));
      endcase
      mode = ($urandom_range(0, 9) == 0) ? 1 + int'($urandom_range(0, 1)) : 0;
      run_bottle(mode, int'($urandom_range(0, 10)), int'($urandom_range(1, 25)),
                 8'(ci), 8'(ti), int'($urandom_range(6, 10)));
    end

    // drive the narrow counter to saturation and past it
    for (int b = 0; b < SMALL_MAX + 2; b++) run_bottle(0, 1, 3, 8'd10, 8'd20, 6);
    chk("small_done_saturated", bus_s.bottles_done, SMALL_MAX);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
